// File: rtl/operand_src_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_src_pkg
//  Description : Shared definitions for the operand-source stage: per-operand
//                mode encodings, skid-buffer state encoding and a helper that
//                extracts one channel's mode field from the instruction word.
//  Revision    : 1.0  initial release
// ============================================================================
package operand_src_pkg;

    // Per-operand source mode encodings
    localparam logic [1:0] MODE_REG = 2'b00;  // pass register address
    localparam logic [1:0] MODE_IMM = 2'b01;  // pass immediate value
    localparam logic [1:0] MODE_FWD = 2'b10;  // pass forwarded write-back
    localparam logic [1:0] MODE_RSV = 2'b11;  // reserved, flagged as error

    // Skid-buffer occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;   // nothing held
    localparam logic [1:0] ST_ONE   = 2'd1;   // output register occupied
    localparam logic [1:0] ST_FULL  = 2'd2;   // output and skid occupied

    // Mode field of channel ch lives at op_code[mode_lsb + 2*ch +: 2]
    function automatic logic [1:0] get_mode(input logic [31:0] op_code,
                                            input int          mode_lsb,
                                            input int          ch);
        return op_code[mode_lsb + 2*ch +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_src_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_src_if
//  Description : Bundle of the operand-source stage handshake and data bus.
//                master = decode side / bench driver, slave = the stage.
//  Ports       : in_valid/in_ready/op_code/addr_in/imm_in  upstream word
//                wb_valid/wb_data                          write-back strobe
//                out_valid/out_ready/opnd_out/is_imm_out/err_out downstream
//  Revision    : 1.0  initial release
// ============================================================================
interface operand_src_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OPS    = 2
) ();
    logic                          in_valid;
    logic                          in_ready;
    logic [31:0]                   op_code;
    logic [NUM_OPS*DATA_WIDTH-1:0] addr_in;
    logic [NUM_OPS*DATA_WIDTH-1:0] imm_in;
    logic                          wb_valid;
    logic [DATA_WIDTH-1:0]         wb_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_OPS*DATA_WIDTH-1:0] opnd_out;
    logic [NUM_OPS-1:0]            is_imm_out;
    logic                          err_out;

    modport master (
        output in_valid, op_code, addr_in, imm_in, wb_valid, wb_data, out_ready,
        input  in_ready, out_valid, opnd_out, is_imm_out, err_out
    );

    modport slave (
        input  in_valid, op_code, addr_in, imm_in, wb_valid, wb_data, out_ready,
        output in_ready, out_valid, opnd_out, is_imm_out, err_out
    );
endinterface
`default_nettype wire

// File: rtl/operand_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : operand_skid_buf
//  Description : Generic two-entry valid/ready skid buffer. All outputs,
//                including i_ready's counterpart o_ready, are registered, so
//                there is no combinational path from i_ready to o_ready.
//  Ports       : clk, rst               clock, synchronous active-high reset
//                i_valid/o_ready/i_data upstream side
//                o_valid/i_ready/o_data downstream side
//  Revision    : 1.0  initial release
// ============================================================================
module operand_skid_buf
    import operand_src_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_accept;

    // r_in_ready mirrors (state != FULL) except it stays low for one cycle
    // after reset, which also blocks any transfer presented during reset.
    assign w_accept = i_valid & r_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_out_data  <= i_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept && !i_ready) begin
                        // Output is stalled: park the new word in the skid
                        r_skid_data <= i_data;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_FULL;
                    end else if (w_accept) begin
                        r_out_data <= i_data;
                    end else if (i_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (i_ready) begin
                        r_out_data <= r_skid_data;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule
`default_nettype wire

// File: rtl/operand_src_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_src_stage
//  Description : Registered operand-source stage. Each channel picks its
//                operand from the register address, the immediate, or the
//                last written-back result according to its mode field. The
//                selection is frozen at accept time and carried through a
//                skid buffer for full throughput under back-pressure.
//  Ports       : clk, rst   clock, synchronous active-high reset
//                bus        operand_src_if.slave (handshakes, data, write-back)
//  Revision    : 1.0  initial release
// ============================================================================
module operand_src_stage
    import operand_src_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OPS    = 2,
    parameter int MODE_LSB   = 28
) (
    input  logic         clk,
    input  logic         rst,
    operand_src_if.slave bus
);

    // Payload layout: {err, is_imm[NUM_OPS-1:0], opnd[NUM_OPS*DATA_WIDTH-1:0]}
    localparam int c_opnd_w    = NUM_OPS * DATA_WIDTH;
    localparam int c_payload_w = 1 + NUM_OPS + c_opnd_w;

    logic [DATA_WIDTH-1:0]  r_last_result;
    logic                   r_fwd_seen;
    logic [DATA_WIDTH-1:0]  w_fwd_val;
    logic                   w_fwd_ok;
    logic [c_opnd_w-1:0]    w_opnd;
    logic [NUM_OPS-1:0]     w_is_imm;
    logic [NUM_OPS-1:0]     w_err_ch;
    logic [c_payload_w-1:0] w_in_data;
    logic [c_payload_w-1:0] w_out_data;

    // Write-back is tracked every cycle, independent of the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_result <= '0;
            r_fwd_seen    <= 1'b0;
        end else if (bus.wb_valid) begin
            r_last_result <= bus.wb_data;
            r_fwd_seen    <= 1'b1;
        end
    end

    // Same-cycle bypass: a write-back coincident with the accept wins
    assign w_fwd_val = bus.wb_valid ? bus.wb_data : r_last_result;
    assign w_fwd_ok  = bus.wb_valid | r_fwd_seen;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_chan
            logic [1:0] w_mode;
            assign w_mode = get_mode(bus.op_code, MODE_LSB, gi);

            // Reserved mode falls back to the register address
            assign w_opnd[gi*DATA_WIDTH +: DATA_WIDTH] =
                (w_mode == MODE_IMM) ? bus.imm_in[gi*DATA_WIDTH +: DATA_WIDTH] :
                (w_mode == MODE_FWD) ? (w_fwd_ok ? w_fwd_val : '0) :
                                       bus.addr_in[gi*DATA_WIDTH +: DATA_WIDTH];

            assign w_is_imm[gi] = (w_mode == MODE_IMM) || (w_mode == MODE_FWD);
            assign w_err_ch[gi] = (w_mode == MODE_RSV) ||
                                  ((w_mode == MODE_FWD) && !w_fwd_ok);
        end
    endgenerate

    assign w_in_data = {(|w_err_ch), w_is_imm, w_opnd};

    operand_skid_buf #(
        .WIDTH (c_payload_w)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  (w_in_data),
        .o_valid (bus.out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out_data)
    );

    assign bus.opnd_out   = w_out_data[c_opnd_w-1:0];
    assign bus.is_imm_out = w_out_data[c_opnd_w +: NUM_OPS];
    assign bus.err_out    = w_out_data[c_payload_w-1];

endmodule
`default_nettype wire

// File: tb/tb_operand_src_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_src_stage
//  Description : Self-checking bench. Instance A (2 channels, mode LSB 28)
//                takes directed vectors; instance B (3 channels, mode LSB 26)
//                takes a toggling valid/ready stream checked by a scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_src_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    operand_src_if #(.DATA_WIDTH(32), .NUM_OPS(2)) ia ();
    operand_src_if #(.DATA_WIDTH(32), .NUM_OPS(3)) ib ();

    operand_src_stage #(.DATA_WIDTH(32), .NUM_OPS(2), .MODE_LSB(28)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    operand_src_stage #(.DATA_WIDTH(32), .NUM_OPS(3), .MODE_LSB(26)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [99:0] exp_q[$];
    logic [31:0] m_last;
    logic        m_seen;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [63:0] opnd,
                         input logic [1:0] imm, input logic err);
        chk({tag, "_valid"}, ia.out_valid, v);
        chk({tag, "_opnd"}, ia.opnd_out, opnd);
        chk({tag, "_imm"}, ia.is_imm_out, imm);
        chk({tag, "_err"}, ia.err_out, err);
    endtask

    // Reference selection for instance B, evaluated at accept time
    function automatic logic [99:0] model_b(input logic [31:0] op, input logic [95:0] a,
                                            input logic [95:0] im, input logic wbv,
                                            input logic [31:0] wbd, input logic [31:0] last,
                                            input logic seen);
        logic [95:0] o;
        logic [2:0]  ii;
        logic        e;
        logic [31:0] fv;
        logic        ok;
        logic [1:0]  m;
        o  = '0;
        ii = '0;
        e  = 1'b0;
        fv = wbv ? wbd : last;
        ok = wbv | seen;
        for (int c = 0; c < 3; c++) begin
            m = op[26 + 2*c +: 2];
            case (m)
                2'b00: o[c*32 +: 32] = a[c*32 +: 32];
                2'b01: begin o[c*32 +: 32] = im[c*32 +: 32]; ii[c] = 1'b1; end
                2'b10: begin
                    ii[c] = 1'b1;
                    if (ok) o[c*32 +: 32] = fv;
                    else    e = 1'b1;
                end
                default: begin o[c*32 +: 32] = a[c*32 +: 32]; e = 1'b1; end
            endcase
        end
        return {e, ii, o};
    endfunction

    // Score the word leaving B at the coming edge, if any
    task automatic pop_b();
        logic [99:0] got;
        if (ib.out_valid && ib.out_ready) begin
            got = {ib.err_out, ib.is_imm_out, ib.opnd_out};
            if (exp_q.size() == 0) chk("strm_underflow", 1, 0);
            else                   chk("strm_word", got, exp_q.pop_front());
        end
    endtask

    task automatic drive_b(input logic v);
        ib.in_valid = v;
        ib.op_code  = $urandom;
        ib.addr_in  = {$urandom, $urandom, $urandom};
        ib.imm_in   = {$urandom, $urandom, $urandom};
        ib.wb_valid = ($urandom_range(0, 7) == 0);
        ib.wb_data  = $urandom;
    endtask

    // Returns 1 if B accepts at the coming edge; updates the model
    task automatic acc_b(output logic taken);
        taken = ib.in_valid && ib.in_ready;
        if (taken)
            exp_q.push_back(model_b(ib.op_code, ib.addr_in, ib.imm_in,
                                    ib.wb_valid, ib.wb_data, m_last, m_seen));
        if (ib.wb_valid) begin
            m_last = ib.wb_data;
            m_seen = 1'b1;
        end
    endtask

    task automatic drain_b(input string tag);
        for (int k = 0; k < 20 && (exp_q.size() != 0 || ib.out_valid); k++) begin
            ib.in_valid  = 1'b0;
            ib.wb_valid  = 1'b0;
            ib.out_ready = 1'b1;
            pop_b();
            step();
        end
        chk({tag, "_qempty"}, exp_q.size(), 0);
        chk({tag, "_idle"}, ib.out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic taken;
        int   acc;

        rst = 1'b1;
        ia.in_valid = 0; ia.op_code = 0; ia.addr_in = 0; ia.imm_in = 0;
        ia.wb_valid = 0; ia.wb_data = 0; ia.out_ready = 0;
        ib.in_valid = 0; ib.op_code = 0; ib.addr_in = 0; ib.imm_in = 0;
        ib.wb_valid = 0; ib.wb_data = 0; ib.out_ready = 0;
        m_last = '0;
        m_seen = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        chk_a("rst", 0, 64'h0, 2'b00, 0);
        chk("rst_ready", ia.in_ready, 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", ia.in_ready, 1);

        // ---------------- single word ----------------
        ia.addr_in   = {32'h77, 32'h10};
        ia.imm_in    = {32'h55, 32'h99};
        ia.op_code   = 32'h4000_0000;
        ia.out_ready = 1;
        ia.in_valid  = 1;
        step();
        ia.in_valid = 0;
        chk_a("single", 1, {32'h55, 32'h10}, 2'b10, 0);
        step();
        chk("single_drain", ia.out_valid, 0);

        // ---------------- forward before any write-back ----------------
        ia.op_code  = 32'h2000_0000;
        ia.in_valid = 1;
        step();
        ia.in_valid = 0;
        chk_a("fwd_nowb", 1, {32'h77, 32'h0}, 2'b01, 1);
        step();

        // ---------------- reserved mode on ch1 ----------------
        ia.op_code  = 32'hC000_0000;
        ia.in_valid = 1;
        step();
        ia.in_valid = 0;
        chk_a("rsv", 1, {32'h77, 32'h10}, 2'b00, 1);
        step();

        // ---------------- forwarding ----------------
        ia.wb_valid = 1; ia.wb_data = 32'hDEAD;
        step();
        ia.wb_valid = 0;
        ia.op_code  = 32'h2000_0000;
        ia.in_valid = 1;
        step();
        chk_a("fwd_prev", 1, {32'h77, 32'hDEAD}, 2'b01, 0);
        ia.wb_valid = 1; ia.wb_data = 32'hBEEF;
        step();
        chk_a("fwd_same", 1, {32'h77, 32'hBEEF}, 2'b01, 0);
        ia.in_valid = 0; ia.out_ready = 0;
        ia.wb_data  = 32'h1234;
        step();
        ia.wb_valid = 0;
        chk_a("fwd_hold", 1, {32'h77, 32'hBEEF}, 2'b01, 0);
        step();
        chk_a("fwd_hold2", 1, {32'h77, 32'hBEEF}, 2'b01, 0);
        ia.out_ready = 1; ia.in_valid = 1;
        step();
        ia.in_valid = 0;
        chk_a("fwd_last", 1, {32'h77, 32'h1234}, 2'b01, 0);
        step();
        chk("fwd_drain", ia.out_valid, 0);

        // ---------------- back-pressure ----------------
        ia.op_code = 32'h5000_0000;
        ia.out_ready = 0;
        ia.in_valid = 1; ia.imm_in = {32'h101, 32'h201};
        step();
        chk("bp_ready1", ia.in_ready, 1);
        ia.imm_in = {32'h102, 32'h202};
        step();
        chk("bp_ready2", ia.in_ready, 0);
        chk_a("bp_hold", 1, {32'h101, 32'h201}, 2'b11, 0);
        ia.imm_in = {32'h103, 32'h203};
        step();
        chk("bp_ready3", ia.in_ready, 0);
        chk_a("bp_stall", 1, {32'h101, 32'h201}, 2'b11, 0);
        ia.out_ready = 1;
        step();
        chk_a("bp_out2", 1, {32'h102, 32'h202}, 2'b11, 0);
        chk("bp_ready_back", ia.in_ready, 1);
        step();
        ia.in_valid = 0;
        chk_a("bp_out3", 1, {32'h103, 32'h203}, 2'b11, 0);
        step();
        chk("bp_drain", ia.out_valid, 0);

        // ---------------- reset while FULL ----------------
        ia.out_ready = 0;
        ia.in_valid = 1; ia.imm_in = {32'h104, 32'h204};
        step();
        ia.imm_in = {32'h105, 32'h205};
        step();
        chk("full_ready", ia.in_ready, 0);
        ia.imm_in = {32'h106, 32'h206};
        rst = 1;
        step();
        chk_a("rst_full", 0, 64'h0, 2'b00, 0);
        chk("rst_full_ready", ia.in_ready, 0);
        rst = 0; ia.in_valid = 0;
        step();
        chk("post_rst_ready", ia.in_ready, 1);
        chk("post_rst_empty", ia.out_valid, 0);
        ia.op_code = 32'h2000_0000; ia.out_ready = 1; ia.in_valid = 1;
        step();
        ia.in_valid = 0;
        chk_a("post_rst_word", 1, {32'h77, 32'h0}, 2'b01, 1);
        step();
        chk("post_rst_alone", ia.out_valid, 0);

        // ---------------- B: toggling stream, 1000 words ----------------
        acc = 0;
        for (int cyc = 0; cyc < 20000 && acc < 1000; cyc++) begin
            ib.out_ready = ($urandom_range(0, 3) != 0);
            pop_b();
            drive_b($urandom_range(0, 1) == 1);
            acc_b(taken);
            if (taken) acc++;
            step();
        end
        chk("strm_count", acc, 1000);
        drain_b("strm");

        // ---------------- B: full throughput ----------------
        acc = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            ib.out_ready = 1'b1;
            pop_b();
            drive_b(1'b1);
            acc_b(taken);
            if (taken) acc++;
            step();
        end
        chk("thru_count", acc, 50);
        drain_b("thru");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_src_stage.md
# operand_src_stage

Registered operand-source stage for the CPU decode path. It is the parametrised successor of the single-bit address/input mux. Per-operand mode fields in the opcode select each operand's source: register address, immediate input, or the last written-back result. A valid/ready handshake with a skid buffer gives full throughput under back-pressure. It sits between instruction decode and register-file read.

## Interface
- DATA_WIDTH, 32, width of every address/immediate/result word
- NUM_OPS, 2, operand channel count (1..8)
- MODE_LSB, 28, opcode bit index of operand 0's 2-bit mode field; operand i uses op_code[MODE_LSB+2i +: 2]; MODE_LSB+2*NUM_OPS ≤ 32
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept; registered
- op_code  in  32  instruction word
- addr_in  in  NUM_OPS*DATA_WIDTH  register addresses, operand i at [i*DATA_WIDTH +: DATA_WIDTH]
- imm_in  in  NUM_OPS*DATA_WIDTH  immediates, same packing
- wb_valid  in  1  write-back result strobe
- wb_data  in  DATA_WIDTH  write-back result
- out_valid  out  1  downstream word valid
- out_ready  in  1  downstream accepts
- opnd_out  out  NUM_OPS*DATA_WIDTH  selected operand per channel
- is_imm_out  out  NUM_OPS  1 = channel i is a value (immediate or forwarded), 0 = register address
- err_out  out  1  reserved mode or forward-before-write-back in this word

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Mode per channel:
  - 00: opnd = addr_in[i], is_imm=0.
  - 01: opnd = imm_in[i], is_imm=1.
  - 10: opnd = fwd value, is_imm=1.
  - 11: reserved; behaves as 00 and sets err.
- fwd value = wb_data if wb_valid in the accept cycle (same-cycle bypass), else the last_result register.
- last_result loads wb_data on every wb_valid. fwd_seen sets on the first wb_valid.
- Mode 10 with fwd_seen=0 and no same-cycle wb_valid: opnd=0, err set.
- err_out = OR over channels, captured with the word.
- Selection is computed at accept time. A word's operands do not change after capture, even if later wb_valid pulses occur.
- Storage is an output register plus one skid entry. States:
  - EMPTY: out_valid=0.
  - ONE: out_valid=1, skid empty.
  - FULL: out_valid=1, skid occupied.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept & !out_ready → FULL (new word to skid).
  - ONE + accept & out_ready → ONE (new word to output).
  - ONE + out_ready & !accept → EMPTY.
  - FULL + out_ready → ONE (skid moves to output).
- in_ready = (state != FULL). No accept is possible in FULL.
- Ordering is strict FIFO. No word is dropped or duplicated.

## Timing
- Latency: a word accepted at edge N appears on out_valid/opnd_out after edge N (1 cycle) when the stage is EMPTY or drains the same cycle.
- in_ready is a pure register output. No combinational path from out_ready to in_ready.
- Outputs are stable while out_valid & !out_ready.
- During and after rst:
  - out_valid=0, in_ready=0 while rst is high, 1 the cycle after rst falls.
  - opnd_out=0, is_imm_out=0, err_out=0.
  - last_result=0, fwd_seen=0, state EMPTY.
- rst mid-operation discards the output and skid words. A transfer presented in the rst cycle is ignored.
- wb_valid is sampled every cycle regardless of handshake state.

## Structure
- Package operand_src_pkg holds:
  - mode localparams MODE_REG=2'b00, MODE_IMM=2'b01, MODE_FWD=2'b10, MODE_RSV=2'b11;
  - state encoding ST_EMPTY/ST_ONE/ST_FULL;
  - a function extracting channel i's mode from op_code.
- One sub-module: operand_skid_buf, a generic 2-entry valid/ready skid buffer with width parameter. It carries {err, is_imm, opnd} as a packed payload. The top level holds source selection and the forward register.

## Test plan
- Reset then single word: op_code[31:28]=4'b0100, addr_in ch0=0x10, imm_in ch1=0x55, out_ready=1 → next cycle out_valid=1, opnd ch0=0x10/is_imm=0, ch1=0x55/is_imm=1, err=0.
- Forwarding:
  - wb_valid=1, wb_data=0xDEAD one cycle before accepting mode 10 on ch0 → opnd ch0=0xDEAD.
  - Same-cycle wb_data=0xBEEF with the accept → 0xBEEF.
  - A later wb 0x1234 does not alter the held word.
- Forward before any write-back after reset → opnd=0, err_out=1. Mode 11 on ch1 → addr_in ch1 passed, err_out=1.
- Back-pressure: stream 3 words with out_ready=0 → first 2 accepted, in_ready=0 after the second. Raise out_ready → words emerge in order, in_ready returns 1 the cycle after the first drain.
- Random valid/ready toggling, 1000 words, NUM_OPS=3, MODE_LSB=26 → scoreboard matches exactly, throughput 1 word/cycle when both sides are always ready.
- Assert rst while FULL → the next cycle out_valid=0 and in_ready=0. After release, the first new word emerges alone with none of the old words.
